// File: rtl/mesh_router_pkg.sv
// Shared constants, port enumeration and header routing helpers for mesh_router.
package mesh_router_pkg;

  localparam int NPORTS    = 5;
  localparam int DATA_W    = 64;
  localparam int HDIR_BIT  = 61;
  localparam int VDIR_BIT  = 62;
  localparam int V_HOP_MSB = 55;
  localparam int V_HOP_LSB = 52;
  localparam int H_HOP_MSB = 51;
  localparam int H_HOP_LSB = 48;

  // Port order doubles as the round-robin scan order.
  typedef enum logic [2:0] {
    CW  = 3'd0,
    CCW = 3'd1,
    PE  = 3'd2,
    NS  = 3'd3,
    SN  = 3'd4
  } port_e;

  typedef struct packed {
    port_e             port;
    logic [DATA_W-1:0] pkt;
  } route_t;

  // Modulo-5 add for port indices; both operands are already in 0..4.
  function automatic logic [2:0] port_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
  endfunction

  // Pick the output port from the header and decrement the hop count that
  // is consumed at this hop. Only a nonzero field is ever decremented.
  function automatic route_t route_compute(input logic [DATA_W-1:0] pkt);
    route_t r;
    r.pkt  = pkt;
    r.port = PE;
    if (pkt[H_HOP_MSB:H_HOP_LSB] != 4'd0) begin
      r.port = pkt[HDIR_BIT] ? CW : CCW;
      r.pkt[H_HOP_MSB:H_HOP_LSB] = pkt[H_HOP_MSB:H_HOP_LSB] - 4'd1;
    end else if (pkt[V_HOP_MSB:V_HOP_LSB] != 4'd0) begin
      r.port = pkt[VDIR_BIT] ? NS : SN;
      r.pkt[V_HOP_MSB:V_HOP_LSB] = pkt[V_HOP_MSB:V_HOP_LSB] - 4'd1;
    end else begin
      r.port = PE;
    end
    return r;
  endfunction

endpackage

// File: rtl/mesh_router_arb.sv
// Five-request round-robin arbiter; one instance guards each output buffer.
module mesh_router_arb
  import mesh_router_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] req,
  input  logic              enable,
  output logic [NPORTS-1:0] grant
);

  logic [2:0] ptr_r;
  logic [2:0] win_s;
  logic [2:0] idx_s;
  logic       found_s;

  // Scan requests starting at the pointer and grant the first one found.
  always_comb begin
    grant   = '0;
    win_s   = 3'd0;
    idx_s   = 3'd0;
    found_s = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      idx_s = port_add(ptr_r, 3'(k));
      if (enable && !found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        win_s        = idx_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Move the pointer to just past the winner whenever a grant is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= 3'(CW);
    end else if (found_s) begin
      ptr_r <= port_add(win_s, 3'd1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/mesh_router.sv
// Five-port source-routed mesh router with one-deep input and output buffers.
module mesh_router
  import mesh_router_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  router_position,
  output logic        polarity_out,
  input  logic        cwsi,
  input  logic        ccwsi,
  input  logic        pesi,
  input  logic        nssi,
  input  logic        snsi,
  input  logic [63:0] cwdi,
  input  logic [63:0] ccwdi,
  input  logic [63:0] pedi,
  input  logic [63:0] nsdi,
  input  logic [63:0] sndi,
  output logic        cwri,
  output logic        ccwri,
  output logic        peri,
  output logic        nsri,
  output logic        snri,
  output logic        cwso,
  output logic        ccwso,
  output logic        peso,
  output logic        nsso,
  output logic        snso,
  output logic [63:0] cwdo,
  output logic [63:0] ccwdo,
  output logic [63:0] pedo,
  output logic [63:0] nsdo,
  output logic [63:0] sndo,
  input  logic        cwro,
  input  logic        ccwro,
  input  logic        pero,
  input  logic        nsro,
  input  logic        snro
);

  logic [NPORTS-1:0] si_s;
  logic [NPORTS-1:0] ro_s;
  logic [NPORTS-1:0] ri_s;
  logic [63:0]       di_s [NPORTS];

  logic [NPORTS-1:0] in_full_r;
  logic [63:0]       in_data_r [NPORTS];
  logic [NPORTS-1:0] out_full_r;
  logic [63:0]       out_data_r [NPORTS];
  logic              polarity_r;

  route_t            rt_s      [NPORTS];
  logic [NPORTS-1:0] req_s     [NPORTS];
  logic [NPORTS-1:0] grant_s   [NPORTS];
  logic [NPORTS-1:0] granted_s;
  logic [NPORTS-1:0] load_s;
  logic [63:0]       out_next_s [NPORTS];

  // Bit / array index equals the port_e value.
  assign si_s = {snsi, nssi, pesi, ccwsi, cwsi};
  assign ro_s = {snro, nsro, pero, ccwro, cwro};
  assign di_s[CW]  = cwdi;
  assign di_s[CCW] = ccwdi;
  assign di_s[PE]  = pedi;
  assign di_s[NS]  = nsdi;
  assign di_s[SN]  = sndi;

  // An input buffer accepts only when empty and the router is out of reset.
  assign ri_s = ~in_full_r & {NPORTS{~reset}};

  assign cwri  = ri_s[CW];
  assign ccwri = ri_s[CCW];
  assign peri  = ri_s[PE];
  assign nsri  = ri_s[NS];
  assign snri  = ri_s[SN];

  assign cwso  = out_full_r[CW];
  assign ccwso = out_full_r[CCW];
  assign peso  = out_full_r[PE];
  assign nsso  = out_full_r[NS];
  assign snso  = out_full_r[SN];

  assign cwdo  = out_data_r[CW];
  assign ccwdo = out_data_r[CCW];
  assign pedo  = out_data_r[PE];
  assign nsdo  = out_data_r[NS];
  assign sndo  = out_data_r[SN];

  assign polarity_out = polarity_r;

  // Route and hop-decrement each buffered header.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      rt_s[i] = route_compute(in_data_r[i]);
    end
  end

  // Build each output's request vector from the full inputs routed to it.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        req_s[o][i] = in_full_r[i] && (rt_s[i].port == port_e'(o));
      end
    end
  end

  // Arbitration only happens into an empty output buffer, so a drained
  // buffer is refilled no earlier than the following edge.
  for (genvar g = 0; g < NPORTS; g++) begin : g_arb
    mesh_router_arb u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (req_s[g]),
      .enable (~out_full_r[g]),
      .grant  (grant_s[g])
    );
  end

  // One-hot crossbar: merge granted packets and flag granted inputs.
  always_comb begin
    granted_s = '0;
    load_s    = '0;
    for (int o = 0; o < NPORTS; o++) begin
      out_next_s[o] = 64'd0;
      load_s[o]     = |grant_s[o];
      for (int i = 0; i < NPORTS; i++) begin
        out_next_s[o] = out_next_s[o] | ({64{grant_s[o][i]}} & rt_s[i].pkt);
        granted_s[i]  = granted_s[i] | grant_s[o][i];
      end
    end
  end

  // Input buffers: fill on handshake, empty when switched to an output.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_full_r <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        in_data_r[i] <= 64'd0;
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (si_s[i] && ri_s[i]) begin
          in_full_r[i] <= 1'b1;
          in_data_r[i] <= di_s[i];
        end else if (granted_s[i]) begin
          in_full_r[i] <= 1'b0;
        end else begin
          in_full_r[i] <= in_full_r[i];
        end
      end
    end
  end

  // Output buffers: load from the switch, empty on downstream handshake;
  // data is kept after the transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_full_r <= '0;
      for (int o = 0; o < NPORTS; o++) begin
        out_data_r[o] <= 64'd0;
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (load_s[o]) begin
          out_full_r[o] <= 1'b1;
          out_data_r[o] <= out_next_s[o];
        end else if (out_full_r[o] && ro_s[o]) begin
          out_full_r[o] <= 1'b0;
        end else begin
          out_full_r[o] <= out_full_r[o];
        end
      end
    end
  end

  // Free-running phase bit seeded from the tile position.
  always_ff @(posedge clk) begin
    if (reset) begin
      polarity_r <= router_position[0];
    end else begin
      polarity_r <= ~polarity_r;
    end
  end

endmodule

// File: tb/tb_mesh_router.sv
// Self-checking bench for mesh_router: directed scenarios plus random traffic
// against a cycle-level behavioural model of the router.
module tb_mesh_router;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  router_position = 4'b0101;
  logic [4:0]  si = 5'd0;
  logic [4:0]  ro = 5'd0;
  logic [63:0] di [5];
  logic [4:0]  so_w;
  logic [4:0]  ri_w;
  logic [63:0] do_w [5];
  logic        pol_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state (index 0..4 = cw, ccw, pe, ns, sn)
  bit          m_in_full  [5];
  logic [63:0] m_in       [5];
  bit          m_out_full [5];
  logic [63:0] m_out      [5];
  int          m_ptr      [5];
  bit          m_pol;

  always #5 clk = ~clk;

  mesh_router dut (
    .clk(clk), .reset(reset), .router_position(router_position), .polarity_out(pol_w),
    .cwsi(si[0]), .ccwsi(si[1]), .pesi(si[2]), .nssi(si[3]), .snsi(si[4]),
    .cwdi(di[0]), .ccwdi(di[1]), .pedi(di[2]), .nsdi(di[3]), .sndi(di[4]),
    .cwri(ri_w[0]), .ccwri(ri_w[1]), .peri(ri_w[2]), .nsri(ri_w[3]), .snri(ri_w[4]),
    .cwso(so_w[0]), .ccwso(so_w[1]), .peso(so_w[2]), .nsso(so_w[3]), .snso(so_w[4]),
    .cwdo(do_w[0]), .ccwdo(do_w[1]), .pedo(do_w[2]), .nsdo(do_w[3]), .sndo(do_w[4]),
    .cwro(ro[0]), .ccwro(ro[1]), .pero(ro[2]), .nsro(ro[3]), .snro(ro[4])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Destination from the header rules: horizontal first, then vertical, else local.
  function automatic int dest(input logic [63:0] p);
    int h, v;
    h = int'((p >> 48) & 64'hF);
    v = int'((p >> 52) & 64'hF);
    if (h != 0) return p[61] ? 0 : 1;
    else if (v != 0) return p[62] ? 3 : 4;
    else return 2;
  endfunction

  function automatic logic [63:0] hop(input logic [63:0] p);
    if (((p >> 48) & 64'hF) != 64'd0) return p - (64'd1 << 48);
    else if (((p >> 52) & 64'hF) != 64'd0) return p - (64'd1 << 52);
    else return p;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int win [5];
    bit acc [5];
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        m_in_full[i] = 0; m_out_full[i] = 0; m_out[i] = 64'd0; m_ptr[i] = 0;
      end
      m_pol = router_position[0];
    end else begin
      for (int o = 0; o < 5; o++) begin
        win[o] = -1;
        if (!m_out_full[o]) begin
          for (int k = 0; k < 5; k++) begin
            int i;
            i = (m_ptr[o] + k) % 5;
            if (win[o] < 0 && m_in_full[i] && dest(m_in[i]) == o) win[o] = i;
          end
        end
      end
      for (int i = 0; i < 5; i++) acc[i] = si[i] && !m_in_full[i];
      for (int o = 0; o < 5; o++) begin
        if (m_out_full[o] && ro[o]) m_out_full[o] = 0;
        if (win[o] >= 0) begin
          m_out_full[o] = 1;
          m_out[o] = hop(m_in[win[o]]);
          m_in_full[win[o]] = 0;
          m_ptr[o] = (win[o] + 1) % 5;
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (acc[i]) begin
          m_in_full[i] = 1;
          m_in[i] = di[i];
        end
      end
      m_pol = !m_pol;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("so[%0d]", i), 64'(so_w[i]), 64'(m_out_full[i]));
      check($sformatf("do[%0d]", i), do_w[i], m_out[i]);
      check($sformatf("ri[%0d]", i), 64'(ri_w[i]), 64'(!m_in_full[i] && !reset));
    end
    check("polarity", 64'(pol_w), 64'(m_pol));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [63:0] gen_pkt();
    logic [63:0] p;
    p = {$urandom, $urandom};
    p[51:48] = 4'($urandom_range(0, 3));
    p[55:52] = 4'($urandom_range(0, 3));
    return p;
  endfunction

  task automatic idle(input int n);
    si = 5'd0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; si = 5'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) di[i] = 64'd0;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    check("rst_so", 64'(so_w), 64'd0);
    check("rst_ri", 64'(ri_w), 64'd0);
    check("rst_pol", 64'(pol_w), 64'd1);
    check("rst_cwdo", do_w[0], 64'd0);
    reset = 1'b0;
    tick();
    check("ri_after_rst", 64'(ri_w), 64'h1F);

    // cw: latency, hold under backpressure, drop after transfer
    ro = 5'b11110;
    si[0] = 1'b1; di[0] = 64'h2002_0000_0000_FA50;
    tick();
    si[0] = 1'b0;
    check("cw_so_at_E", 64'(so_w[0]), 64'd0);
    tick();
    check("cw_so_E1", 64'(so_w[0]), 64'd1);
    check("cw_do_E1", do_w[0], 64'h2001_0000_0000_FA50);
    tick();
    check("cw_do_hold", do_w[0], 64'h2001_0000_0000_FA50);
    ro[0] = 1'b1;
    tick();
    check("cw_so_drop", 64'(so_w[0]), 64'd0);
    check("cw_do_keep", do_w[0], 64'h2001_0000_0000_FA50);

    // ccw, ns, sn, local
    si[2] = 1'b1; di[2] = 64'h0002_0000_0000_6840;
    tick(); si = 5'd0; tick();
    check("ccw_do", do_w[1], 64'h0001_0000_0000_6840);
    idle(2);
    si[3] = 1'b1; di[3] = 64'h4010_0000_0000_C7D4;
    si[4] = 1'b1; di[4] = 64'h0010_0000_FFFF_FFFF;
    tick(); si = 5'd0; tick();
    check("ns_do", do_w[3], 64'h4000_0000_0000_C7D4);
    check("sn_do", do_w[4], 64'h0000_0000_FFFF_FFFF);
    idle(2);
    si[0] = 1'b1; di[0] = 64'h8000_0000_0000_1234;
    tick(); si = 5'd0; tick();
    check("pe_do", do_w[2], 64'h8000_0000_0000_1234);
    check("pe_only", 64'(so_w), 64'h04);
    idle(2);

    // Contention on cw output right after reset (pointer at cw)
    do_reset();
    ro = 5'h1F;
    si[2] = 1'b1; di[2] = 64'h2012_0000_000F_BA34;
    si[0] = 1'b1; di[0] = 64'h2002_0000_0005_3FDA;
    tick(); si = 5'd0;
    tick();
    check("cont_first", do_w[0], 64'h2001_0000_0005_3FDA);
    check("cont_peri0", 64'(ri_w[2]), 64'd0);
    tick();
    check("cont_peri1", 64'(ri_w[2]), 64'd0);
    tick();
    check("cont_second", do_w[0], 64'h2011_0000_000F_BA34);
    check("cont_so", 64'(so_w[0]), 64'd1);
    check("cont_peri_up", 64'(ri_w[2]), 64'd1);
    idle(2);

    // Backpressure then reset
    ro[0] = 1'b0;
    si[0] = 1'b1; di[0] = 64'h2002_0000_0000_AAAA;
    tick(); si[0] = 1'b0; tick();
    si[0] = 1'b1; di[0] = 64'h2002_0000_0000_BBBB;
    tick(); si[0] = 1'b0;
    idle(3);
    check("bp_so", 64'(so_w[0]), 64'd1);
    check("bp_do", do_w[0], 64'h2001_0000_0000_AAAA);
    check("bp_cwri", 64'(ri_w[0]), 64'd0);
    router_position = 4'b0010;
    reset = 1'b1;
    tick();
    check("rst2_so", 64'(so_w), 64'd0);
    check("rst2_ri", 64'(ri_w), 64'd0);
    check("rst2_pol", 64'(pol_w), 64'd0);
    reset = 1'b0;
    tick();
    check("rel_ri", 64'(ri_w), 64'h1F);
    check("rel_pol1", 64'(pol_w), 64'd1);
    tick();
    check("rel_pol2", 64'(pol_w), 64'd0);

    // Random traffic with random backpressure and occasional reset
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      router_position = 4'($urandom_range(0, 15));
      for (int i = 0; i < 5; i++) begin
        ro[i] = ($urandom_range(0, 3) != 0);
        si[i] = !m_in_full[i] && ($urandom_range(0, 1) == 1);
        di[i] = gen_pkt();
      end
      tick();
    end
    reset = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
